// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported unified memory between the IF
//                stage (fetch) and the MEM stage (load/store). MEM wins a
//                tie. A watchdog aborts any access that is never acked.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST,
    // Instruction-fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    // Load/store port
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_valid,
    output logic              mem_stall,
    // Memory side
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    // Status
    output logic              timeout_err
);

    // Watchdog counter only needs to reach TIMEOUT-1
    localparam int                 c_CNT_W    = $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BUSY_IF  = 2'd1,
        S_BUSY_MEM = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_ram_req;
    logic                r_ram_we;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_wdata;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_mem_rdata;
    logic                r_if_valid;
    logic                r_mem_valid;
    logic                r_timeout_err;
    logic                w_finish;

    // An access ends either on ack or when the watchdog expires; ack wins a tie
    assign w_finish = ram_ack || (r_cnt == c_CNT_LAST);

    // Arbitration FSM, memory handshake, read-data capture and watchdog
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_ram_req     <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_wdata   <= '0;
            r_if_rdata    <= '0;
            r_mem_rdata   <= '0;
            r_if_valid    <= 1'b0;
            r_mem_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_if_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    // MEM holds the older instruction, so it is served first
                    if (mem_req) begin
                        r_ram_req   <= 1'b1;
                        r_ram_we    <= mem_we;
                        r_ram_addr  <= mem_addr;
                        r_ram_wdata <= mem_wdata;
                        r_state     <= S_BUSY_MEM;
                    end else if (if_req) begin
                        r_ram_req  <= 1'b1;
                        r_ram_we   <= 1'b0;
                        r_ram_addr <= if_addr;
                        r_state    <= S_BUSY_IF;
                    end
                end
                S_BUSY_IF, S_BUSY_MEM: begin
                    if (w_finish) begin
                        r_ram_req <= 1'b0;
                        r_state   <= S_DONE;
                        if (!ram_ack) begin
                            r_timeout_err <= 1'b1;
                        end
                        if (r_state == S_BUSY_IF) begin
                            r_if_valid <= 1'b1;
                            r_if_rdata <= ram_ack ? ram_rdata : '0;
                        end else begin
                            r_mem_valid <= 1'b1;
                            // Stores keep the last load data unless aborted
                            if (!ram_ack) begin
                                r_mem_rdata <= '0;
                            end else if (!r_ram_we) begin
                                r_mem_rdata <= ram_rdata;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_DONE: begin
                    // Requesters still hold the finished request this cycle
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_req     = r_ram_req;
    assign ram_we      = r_ram_we;
    assign ram_addr    = r_ram_addr;
    assign ram_wdata   = r_ram_wdata;
    assign if_rdata    = r_if_rdata;
    assign mem_rdata   = r_mem_rdata;
    assign if_valid    = r_if_valid;
    assign mem_valid   = r_mem_valid;
    assign timeout_err = r_timeout_err;

    // A stage is stalled from its request up to, not including, its valid
    assign if_stall  = if_req  & ~r_if_valid;
    assign mem_stall = mem_req & ~r_mem_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Scoreboard bench for mem_port_arbiter: directed timing cases
//                followed by concurrent randomized IF/MEM traffic against a
//                behavioural memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
    logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic        ram_ack = 1'b0;
    logic        if_valid, if_stall, mem_valid, mem_stall;
    logic        ram_req, ram_we, timeout_err;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .mem_stall(mem_stall),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
        .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        bit          store;
        bit          tmo;
    } exp_t;

    exp_t        if_q[$];
    exp_t        mem_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          exp_err = 1'b0;
    logic [31:0] exp_mem_last = '0;
    int          if_delay = 1;
    int          mem_delay = 1;
    bit          force_ack = 1'b0;
    bit          mon_en = 1'b0;
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] ram_mem[logic [31:0]];

    function automatic logic [31:0] hashv(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : hashv(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_fail(input string name, input int cyc);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no valid after %0d cycles, required within 100", name, cyc);
    endtask

    // Memory responder: acks the k-th BUSY cycle, k chosen by the requester
    initial begin : responder
        int n;
        int dly;
        bit own_mem;
        n = 0; dly = 1; own_mem = 1'b0;
        forever begin
            @(posedge CLK); #1;
            ram_ack   = 1'b0;
            ram_rdata = $urandom();
            if (ram_req) begin
                n++;
                if (n == 1) begin
                    own_mem = ram_addr[31];
                    dly     = own_mem ? mem_delay : if_delay;
                end
                check("ram_addr", ram_addr, own_mem ? mem_addr : if_addr);
                check("ram_we", {31'd0, ram_we}, {31'd0, own_mem ? mem_we : 1'b0});
                if (own_mem && mem_we) check("ram_wdata", ram_wdata, mem_wdata);
                if (n > TO) check("ram_req_len", n, TO);
                if (n == dly) begin
                    ram_ack   = 1'b1;
                    ram_rdata = ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : hashv(ram_addr);
                    if (ram_we) ram_mem[ram_addr] = ram_wdata;
                end
            end else begin
                n = 0;
                // stray acks outside an access must be ignored
                if ($urandom_range(0, 5) == 0) ram_ack = 1'b1;
            end
            if (force_ack) ram_ack = 1'b1;
        end
    end

    // Monitor: pops the expected response whenever a stage sees valid
    initial begin : monitor
        exp_t        e;
        logic [31:0] d;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                check("if_stall", {31'd0, if_stall}, {31'd0, if_req & ~if_valid});
                check("mem_stall", {31'd0, mem_stall}, {31'd0, mem_req & ~mem_valid});
                check("dual_valid", {31'd0, if_valid & mem_valid}, 32'd0);
                if (if_valid) begin
                    if (if_q.size() == 0) begin
                        check("if_unexpected_valid", {31'd0, if_valid}, 32'd0);
                    end else begin
                        e = if_q.pop_front();
                        exp_err |= e.tmo;
                        check("if_rdata", if_rdata, e.tmo ? 32'd0 : e.data);
                    end
                end
                if (mem_valid) begin
                    if (mem_q.size() == 0) begin
                        check("mem_unexpected_valid", {31'd0, mem_valid}, 32'd0);
                    end else begin
                        e = mem_q.pop_front();
                        exp_err |= e.tmo;
                        d = e.tmo ? 32'd0 : (e.store ? exp_mem_last : e.data);
                        exp_mem_last = d;
                        check("mem_rdata", mem_rdata, d);
                    end
                end
                check("timeout_err", {31'd0, timeout_err}, {31'd0, exp_err});
            end
        end
    end

    task automatic do_if(input logic [31:0] addr, input int k, output int lat);
        exp_t e;
        int   cyc;
        cyc    = 0;
        e.data = rd_ref(addr); e.store = 1'b0; e.tmo = (k > TO);
        if_q.push_back(e);
        if_delay = k; if_addr = addr; if_req = 1'b1;
        while (cyc < 100) begin
            @(posedge CLK); #1;
            cyc++;
            if (if_valid) break;
        end
        if (!if_valid) wait_fail("if_wait", cyc);
        if_req = 1'b0;
        lat    = cyc;
        @(posedge CLK); #1;
    endtask

    task automatic do_mem(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input int k, output int lat);
        exp_t e;
        int   cyc;
        cyc     = 0;
        e.store = we; e.tmo = (k > TO);
        e.data  = we ? 32'd0 : rd_ref(addr);
        if (we && !e.tmo) ref_mem[addr] = wd;
        mem_q.push_back(e);
        mem_delay = k; mem_we = we; mem_addr = addr; mem_wdata = wd; mem_req = 1'b1;
        while (cyc < 100) begin
            @(posedge CLK); #1;
            cyc++;
            if (mem_valid) break;
        end
        if (!mem_valid) wait_fail("mem_wait", cyc);
        mem_req = 1'b0;
        lat     = cyc;
        @(posedge CLK); #1;
    endtask

    initial begin : main
        int lat, lat_m, lat_i;
        ref_mem[32'h40] = 32'h8C22_0004;
        ram_mem[32'h40] = 32'h8C22_0004;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ram_req", {31'd0, ram_req}, 32'd0);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        RST = 1'b0; mon_en = 1'b1;

        // Lone zero-wait fetch: valid two cycles after the request is seen
        do_if(32'h40, 1, lat);
        check("lat_lone_fetch", lat, 2);

        // Collision: MEM first, IF waits through the whole MEM access
        fork
            do_mem(1'b0, 32'h8000_0100, 32'd0, 1, lat_m);
            do_if(32'h44, 1, lat_i);
        join
        check("lat_collision_mem", lat_m, 2);
        check("lat_collision_if", lat_i, 5);

        // Store with three wait cycles, then read it back
        do_mem(1'b1, 32'h8000_0200, 32'hCAFE_F00D, 4, lat);
        check("lat_store_wait3", lat, 5);
        do_mem(1'b0, 32'h8000_0200, 32'd0, 2, lat);
        check("lat_load_back", lat, 3);

        // Watchdog abort, then ack exactly on the last allowed cycle
        do_if(32'h80, TO + 1, lat);
        check("lat_if_abort", lat, TO + 1);
        do_if(32'h84, TO, lat);
        check("lat_if_ack_last", lat, TO + 1);
        do_mem(1'b0, 32'h8000_0300, 32'd0, TO + 1, lat);
        check("lat_mem_abort", lat, TO + 1);

        // Reset in the middle of a MEM access, with an ack that arrives too late
        mem_delay = 3; mem_we = 1'b0; mem_addr = 32'h8000_0400; mem_req = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b1; force_ack = 1'b1;
        @(posedge CLK); #2;
        RST = 1'b0; mem_req = 1'b0;
        exp_err = 1'b0; exp_mem_last = '0;
        check("midrst_ram_req", {31'd0, ram_req}, 32'd0);
        check("midrst_ram_addr", ram_addr, 32'd0);
        check("midrst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("midrst_timeout_err", {31'd0, timeout_err}, 32'd0);
        @(posedge CLK); #2;
        force_ack = 1'b0;
        @(posedge CLK); #1;
        do_if(32'h48, 1, lat);
        check("lat_after_reset", lat, 2);

        // Concurrent randomized traffic from both stages
        fork
            begin : if_traffic
                int g, l;
                for (int i = 0; i < 40; i++) begin
                    g = $urandom_range(0, 3);
                    repeat (g) begin @(posedge CLK); #1; end
                    do_if({22'd0, 8'($urandom_range(0, 255)), 2'b00},
                          $urandom_range(1, TO + 1), l);
                end
            end
            begin : mem_traffic
                int g, l;
                for (int i = 0; i < 40; i++) begin
                    g = $urandom_range(0, 3);
                    repeat (g) begin @(posedge CLK); #1; end
                    do_mem(1'($urandom_range(0, 1)),
                           {1'b1, 23'd0, 6'($urandom_range(0, 15)), 2'b00},
                           $urandom(), $urandom_range(1, TO + 1), l);
                end
            end
        join
        repeat (5) @(posedge CLK);
        #1;
        check("if_q_empty", if_q.size(), 32'd0);
        check("mem_q_empty", mem_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares one single-ported unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the five-stage MIPS pipeline. It grants one access at a time, drives the memory-side request/ack handshake, returns read data to the winning stage and holds the other stage stalled. A watchdog aborts any access the memory never acknowledges.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, maximum BUSY cycles without ram_ack before abort (≥2)

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset; synchronous, active-high
- if_req  in  1  IF fetch request; held with if_addr stable until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction; valid while if_valid=1
- if_valid  out  1  one-cycle completion pulse for IF
- if_stall  out  1  if_req & ~if_valid (combinational)
- mem_req  in  1  MEM access request (MemRead|MemWrite); held stable until mem_valid
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data; valid while mem_valid=1
- mem_valid  out  1  one-cycle completion pulse for MEM (loads and stores)
- mem_stall  out  1  mem_req & ~mem_valid (combinational)
- ram_req  out  1  memory request, high for every BUSY cycle
- ram_we  out  1  latched write enable
- ram_addr  out  ADDR_W  latched address
- ram_wdata  out  DATA_W  latched store data
- ram_rdata  in  DATA_W  memory read data, sampled with ram_ack
- ram_ack  in  1  memory completion, single cycle
- timeout_err  out  1  sticky; set on watchdog abort

## Operation
- States: IDLE, BUSY_IF, BUSY_MEM, DONE.
- IDLE: mem_req=1 → latch mem_we/addr/wdata, go BUSY_MEM; else if_req=1 → latch ram_we=0, if_addr, go BUSY_IF; else stay. MEM wins simultaneous requests (older instruction first).
- BUSY_x: ram_req=1, ram_we/addr/wdata stable from latch. ram_ack=1 → capture ram_rdata into x_rdata (loads/fetches only; stores leave mem_rdata unchanged), go DONE.
- Watchdog: cnt cleared on entry to BUSY, +1 per BUSY cycle without ack. cnt==TIMEOUT-1 and ram_ack=0 → x_rdata=0, timeout_err=1, go DONE. ram_ack in that same cycle wins: normal completion, no error.
- DONE: pulse x_valid for the owner only; requests ignored this cycle (requester still holds the old request); next state IDLE.
- Late ram_ack in IDLE or DONE ignored.
- Reset (any state, including mid-access): state IDLE, ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0, if_valid=0, mem_valid=0, if_rdata=0, mem_rdata=0, timeout_err=0, cnt=0. Outstanding memory transaction abandoned.
- timeout_err clears only on RST.

## Timing
- Request seen in IDLE at cycle t → ram_req=1 from t+1.
- ram_ack at t+k (k≥1) → x_valid=1 at t+k+1 → IDLE at t+k+2.
- Zero-wait memory (ack at t+1): request-to-valid latency 2 cycles; back-to-back accesses every 3 cycles.
- Abort: at most TIMEOUT BUSY cycles; valid at t+TIMEOUT+1.
- x_valid, x_rdata, ram_* registered; only if_stall/mem_stall combinational.
- Stalled stage sees x_stall=1 every cycle from request until its valid cycle, inclusive of the arbitration-loss period.

## Test plan
- Lone fetch: if_req, if_addr=0x40, ack at first BUSY cycle with rdata=0x8C220004 → if_valid at t+2, if_rdata=0x8C220004, ram_we=0, mem_valid never set.
- Collision: if_req and mem_req (load, addr 0x100) both high at t, ack each after 1 cycle with 0x11/0x22 → mem_valid t+2 (0x11), ram_addr=0x40 then from t+4, if_valid t+5 (0x22); if_stall=1 t..t+4.
- Store with 3 wait cycles: mem_we=1, addr 0x200, wdata 0xCAFEF00D, ack at t+4 → ram_we=1, ram_wdata stable t+1..t+4, mem_valid t+5, mem_rdata unchanged.
- Timeout: TIMEOUT=4, no ack → ram_req high t+1..t+4, if_valid t+5, if_rdata=0, timeout_err=1 sticky; ack at cycle 4 of a later access (cnt==3) → no abort, data returned.
- Reset mid-access: RST at t+2 during BUSY_MEM, ack at t+3 → all outputs reset at t+3, no valid pulse, ack ignored, new if_req granted normally afterwards.
